// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default widths for the writeback unit
package wb_pkg;

    localparam int WB_DATA_W     = 32;
    localparam int WB_ADDR_W     = 5;
    localparam int WB_NUM_REGS   = 16;
    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_STARVE_MAX = 3;

    // One pending register-file write: destination index plus its data
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Which producer owns the write port in a given cycle
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback entries with push/pop/full/empty/count
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = WB_FIFO_DEPTH,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    entry_t          store [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    // Full is judged on the current occupancy, so a pop never frees a slot in the same cycle
    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = store[rd_ptr];

    // Entry storage needs no reset; only pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - merges ALU and load results onto the register-file write port (optional WB_BYPASS_EN)
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int NUM_REGS   = WB_NUM_REGS,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_rd,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                err_oob
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          fifo_head;
    entry_t          alu_entry;
    entry_t          sel;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            fifo_push;
    logic            fifo_pop;
    logic [SW-1:0]   starve;
    logic            mem_accept;
    wb_src_e         src;
    logic            commit;
    logic            sel_in_range;
    logic            sel_writes;
    logic            sel_oob;
    logic            issue_ok;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    assign alu_entry = '{rd: alu_rd, data: alu_data};

    // Loads win unless the FIFO has been deferred too long; an empty FIFO never blocks a load
    assign mem_accept = mem_valid && ((starve < STARVE_LIM) || fifo_empty);
    assign mem_ready  = mem_accept;
    assign alu_ready  = !fifo_full;

    // Pick the single producer that owns the write port this cycle
    always_comb begin
        src = SRC_NONE;
        sel = '0;
        if (mem_accept) begin
            src = SRC_MEM;
            sel = '{rd: mem_rd, data: mem_data};
        end else if (fifo_count != '0) begin
            src = SRC_FIFO;
            sel = fifo_head;
        end
`ifdef WB_BYPASS_EN
        else if (alu_valid && fifo_empty) begin
            src = SRC_BYPASS;
            sel = alu_entry;
        end
`endif
    end

    assign commit    = (src != SRC_NONE);
    assign fifo_pop  = (src == SRC_FIFO);
    assign fifo_push = alu_valid && !fifo_full && (src != SRC_BYPASS);

    assign sel_in_range = (32'(sel.rd) < NUM_REGS);
    assign sel_writes   = commit && sel_in_range && (sel.rd != '0);
    assign sel_oob      = commit && !sel_in_range;
    assign issue_ok     = issue_valid && (issue_rd != '0) && (32'(issue_rd) < NUM_REGS);

    // Decode issue/commit indices into per-register set and clear masks
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set_vec[i] = issue_ok && (issue_rd == ADDR_W'(i));
            clr_vec[i] = commit && (sel.rd == ADDR_W'(i));
        end
    end

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (alu_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Count cycles a load has beaten a waiting FIFO; cleared once the FIFO gets its turn or drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (fifo_pop || fifo_empty) begin
            starve <= '0;
        end else if ((src == SRC_MEM) && (starve != STARVE_LIM)) begin
            starve <= starve + 1'b1;
        end
    end

    // Pending-write scoreboard: a new issue beats a retiring write to the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_mask <= '0;
        end else begin
            pend_mask <= (pend_mask & ~clr_vec) | set_vec;
        end
    end

    // Register-file write port; dropped commits still update index/data but never assert the enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            err_oob  <= 1'b0;
        end else begin
            rf_we <= sel_writes;
            if (commit) begin
                rf_rd    <= sel.rd;
                rf_wdata <= sel.data;
            end
            if (sel_oob) begin
                err_oob <= 1'b1;
            end
        end
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the scalar register-file write port: merges ALU and memory-load results into the single write port (rf_we/rf_rd/rf_wdata) of the decode-stage register file.
- Buffers ALU results in a small FIFO. Memory results have priority, with a starvation guard.
- Keeps a pending-write scoreboard that the decode stage uses for hazard stalls.

Parameters:
- DATA_W, 32, result/register data width
- ADDR_W, 5, register index width
- NUM_REGS, 16, number of physical scalar registers (indices >= NUM_REGS are out of range)
- FIFO_DEPTH, 4, ALU result FIFO entries (power of two, >= 2)
- STARVE_MAX, 3, consecutive deferred cycles before the FIFO overrides memory priority

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  FIFO can accept (combinational: not full)
- mem_valid  in  1  load result offered
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load result accepted this cycle (combinational)
- issue_valid  in  1  instruction with a destination issued
- issue_rd  in  ADDR_W  its destination register
- pend_mask  out  NUM_REGS  bit i = write to register i outstanding
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  ADDR_W  register-file write index (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- err_oob  out  1  sticky: a result targeted an index >= NUM_REGS

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_rd=0, rf_wdata=0, pend_mask=0, err_oob=0, FIFO empty, starve counter=0.
- Reset mid-operation discards FIFO contents and pending bits immediately.
- ALU handshake: transfer when alu_valid && alu_ready; the entry is pushed at that edge. The producer holds its data while alu_valid && !alu_ready.
- Commit select, one per cycle:
  - mem_valid and starve<STARVE_MAX: commit mem, mem_ready=1.
  - else if FIFO non-empty: pop the FIFO head and commit it; mem_ready=0.
  - else if mem_valid: commit mem.
- Starve counter:
  - Increments when mem wins while the FIFO is non-empty.
  - Resets to 0 whenever the FIFO commits or the FIFO is empty.
  - Saturates at STARVE_MAX.
- Commit: at the edge, rf_rd/rf_wdata load the selected entry.
  - rf_we=1 only if 0 < rd < NUM_REGS.
  - rd=0: silently dropped, rf_we=0.
  - rd>=NUM_REGS: dropped, err_oob set and held until reset.
- No commit this cycle: rf_we=0; rf_rd/rf_wdata hold their values.
- Latency:
  - mem accepted in cycle N: rf_we high in cycle N+1.
  - ALU accepted in cycle N: earliest rf_we high in cycle N+2.
- FIFO:
  - A push and a pop in the same cycle are both legal, including when the FIFO is full: alu_ready=0 when full; no same-cycle pop credit is given.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Scoreboard:
  - issue_valid sets pend_mask[issue_rd] at the edge.
  - Every commit (including dropped ones) clears pend_mask[rd].
  - Same edge, same register, set and clear: set wins.
  - issue_rd=0 or out of range: ignored.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, no mem commit occurs this cycle and the ALU transfer happens, the ALU result commits directly at that edge without being pushed. ALU latency becomes N+1.
- Undefined: every ALU result passes through the FIFO (latency >= N+2).

Decomposition:
- Package wb_pkg:
  - typedef wb_entry_t (struct: rd, data)
  - enum wb_src_e {SRC_NONE, SRC_MEM, SRC_FIFO, SRC_BYPASS}
  - default width constants
- One sub-module, wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count.
- Select, scoreboard and output registers live in writeback_unit.

Test Plan:
- Reset mid-stream:
  - Stimulus: FIFO holds 3 entries, pend_mask=16'h00F0; assert rst_n=0 asynchronously.
  - Response: rf_we=0 before the next edge, pend_mask=0, alu_ready=1; after release, no stale commit.
- Single ALU op:
  - Stimulus: issue rd=5, then ALU rd=5 data=32'hDEADBEEF accepted in cycle 10.
  - Response: rf_we=1, rf_rd=5, rf_wdata=32'hDEADBEEF in cycle 12 (cycle 11 with WB_BYPASS_EN); pend_mask[5] clears at that edge.
- Memory priority and starvation:
  - Stimulus: FIFO holds 2 entries, mem_valid held high continuously.
  - Response: mem commits 3 cycles, then mem_ready=0 for one cycle while a FIFO entry commits; pattern repeats until the FIFO is empty.
- FIFO full:
  - Stimulus: 4 ALU results pushed with mem_valid high and starve held below threshold.
  - Response: alu_ready=0 after the 4th; a 5th result is held by the producer and accepted the cycle after a pop.
- Dropped writes:
  - Stimulus: mem rd=0 data=7, then mem rd=20.
  - Response: rf_we stays 0 for both; err_oob=1 after the second and stays 1.
- Scoreboard race:
  - Stimulus: issue_rd=3 in the same cycle as a commit to rd=3.
  - Response: pend_mask[3]=1 after the edge.
